fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle MIPS core, directly upstream of `control_unit`. Holds the PC, fetches one 32-bit word per instruction from instruction memory over a ready-based handshake, presents the instruction and its opcode to decode and datapath, and advances the PC from the `Branch`/`Jump` controls and the ALU `zero` flag. A two-state FSM makes instruction-memory wait states transparent to the rest of the core.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/pc_next_calc.sv | 41 ++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, reset PC,
// the fetch FSM state type and the PC arithmetic helpers.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_R_FORMAT = 6'h00;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

    // Word-aligned, sign-extended branch displacement from the immediate field.
    function automatic logic [INSTR_W-1:0] branch_offset(input logic [INSTR_W-1:0] instr);
        return {{14{instr[15]}}, instr[15:0], 2'b00};
    endfunction

    // J-type target keeps the 256 MB region of the delay-free successor.
    function automatic logic [INSTR_W-1:0] jump_target(input logic [INSTR_W-1:0] pc_plus4,
                                                        input logic [INSTR_W-1:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the fetch stage.
// FETCH_JR_EN adds a register-indirect target with the highest priority.
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
`ifdef FETCH_JR_EN
    input  logic               jr,
    input  logic [INSTR_W-1:0] jr_target,
`endif
    output logic [INSTR_W-1:0] next_pc
);

    logic unused_instr_bits;
`ifdef FETCH_JR_EN
    assign unused_instr_bits = ^{instr[31:26], jr_target[1:0]};
`else
    assign unused_instr_bits = ^instr[31:26];
`endif

    // Later assignments win, so a jump masks an undefined branch from jal.
    always_comb begin
        next_pc = pc_plus4;
        if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset(instr);
        end
        if (jump) begin
            next_pc = jump_target(pc_plus4, instr);
        end
`ifdef FETCH_JR_EN
        if (jr) begin
            next_pc = {jr_target[31:2], 2'b00};
        end
`endif
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, retire counter and the
// FETCH/EXEC handshake FSM. Optional macro FETCH_JR_EN adds jr/jr_target/misalign.
//
//   state | meaning
//   FETCH | request imem at pc, wait for imem_ready, latch instr
//   EXEC  | instr valid for one cycle, pc <= next_pc, retired++
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
`ifdef FETCH_JR_EN
    input  logic               jr,
    input  logic [INSTR_W-1:0] jr_target,
    output logic               misalign,
`endif
    output logic [INSTR_W-1:0] retired
);

    localparam logic [INSTR_W-1:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic               load_instr;
    logic               advance;
    logic [INSTR_W-1:0] pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] retired_q;
    logic [INSTR_W-1:0] next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_instr = 1'b0;
        advance    = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    load_instr = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                advance = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    pc_next_calc u_pc_next_calc (
        .pc_plus4  (pc_plus4),
        .instr     (instr_q),
        .branch    (branch),
        .jump      (jump),
        .zero      (zero),
`ifdef FETCH_JR_EN
        .jr        (jr),
        .jr_target (jr_target),
`endif
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= PC_INIT;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            if (load_instr) begin
                instr_q <= imem_rdata;
            end
            if (advance) begin
                pc_q      <= next_pc;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

`ifdef FETCH_JR_EN
    logic misalign_q;

    // Reflects the most recent executed instruction only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (advance) begin
            misalign_q <= jr && (jr_target[1:0] != 2'b00);
        end
    end

    assign misalign = misalign_q;
`endif

    // rst gates the request so an in-flight fetch is dropped at once.
    assign imem_req    = (state_q == FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == EXEC);
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized
// instructions against a per-instruction reference model.
module tb_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] retired;
`ifdef FETCH_JR_EN
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic        misalign;
`endif

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_pc = RPC;
    logic [31:0] m_ret = '0;
    logic        m_mis = 1'b0;
    logic [5:0]  ops [8];

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
`ifdef FETCH_JR_EN
        .jr          (jr),
        .jr_target   (jr_target),
        .misalign    (misalign),
`endif
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Next PC from the architectural rules, using signed integer arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic br, input logic jp, input logic zr);
        logic [31:0]        p4;
        logic signed [15:0] imm;
        int                 off;
        p4  = cur + 32'd4;
        imm = word[15:0];
        off = imm;
        if (jp === 1'b1) return {p4[31:28], word[25:0], 2'b00};
        if (br === 1'b1 && zr === 1'b1) return p4 + 32'(off * 4);
        return p4;
    endfunction

    task automatic scramble_ctrl();
        branch = 1'($urandom);
        jump   = 1'($urandom);
        zero   = 1'($urandom);
`ifdef FETCH_JR_EN
        jr        = 1'($urandom);
        jr_target = $urandom;
`endif
    endtask

    task automatic check_fetch(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, m_pc);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_retired"}, retired, m_ret);
`ifdef FETCH_JR_EN
        chk({tag, "_misalign"}, 32'(misalign), 32'(m_mis));
`endif
    endtask

    // Entered and left at a falling edge with the DUT waiting for a fetch.
    task automatic run_instr(input int w, input logic [31:0] word, input logic br,
                             input logic jp, input logic zr, input logic jrv,
                             input logic [31:0] jrt, input bit abort_exec);
        logic [31:0] nxt;
        for (int i = 0; i < w; i++) begin
            check_fetch("wait");
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            scramble_ctrl();
            @(negedge clk);
        end
        check_fetch("fetch");
        imem_ready = 1'b1;
        imem_rdata = word;
        scramble_ctrl();
        @(negedge clk);
        chk("exec_valid", 32'(instr_valid), 32'd1);
        chk("exec_req", 32'(imem_req), 32'd0);
        chk("exec_instr", instr, word);
        chk("exec_opcode", 32'(opcode), 32'(word[31:26]));
        chk("exec_pc", pc, m_pc);
        chk("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("exec_retired", retired, m_ret);
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        branch = br;
        jump   = jp;
        zero   = zr;
`ifdef FETCH_JR_EN
        jr        = jrv;
        jr_target = jrt;
`endif
        if (abort_exec) begin
            rst = 1'b1;
            @(negedge clk);
            chk("abort_pc", pc, RPC);
            chk("abort_retired", retired, 32'd0);
            chk("abort_instr", instr, 32'd0);
            rst = 1'b0;
            imem_ready = 1'b0;
            m_pc  = RPC;
            m_ret = '0;
            m_mis = 1'b0;
            #1;
        end else begin
            @(negedge clk);
            nxt = ref_next(m_pc, word, br, jp, zr);
`ifdef FETCH_JR_EN
            if (jrv) nxt = {jrt[31:2], 2'b00};
`endif
            m_pc  = nxt;
            m_ret = m_ret + 32'd1;
            m_mis = jrv && (jrt[1:0] != 2'b00);
        end
    endtask

    initial begin
        logic [31:0] word;
        logic        jrv;
        ops = '{OP_LW, OP_SW, OP_R_FORMAT, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_JAL};

        @(negedge clk);
        chk("rst_pc", pc, RPC);
        chk("rst_pc_plus4", pc_plus4, RPC + 32'd4);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_retired", retired, 32'd0);
        rst = 1'b0;
        #1;
        chk("req_after_rst", 32'(imem_req), 32'd1);

        run_instr(0, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        run_instr(0, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("seq_addr", imem_addr, 32'h0000_0008);
        chk("seq_retired", retired, 32'd2);

        run_instr(0, 32'h0C00_0040, 1'bx, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("jal_to_100", imem_addr, 32'h0000_0100);
        run_instr(0, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("beq_taken", imem_addr, 32'h0000_0100);
        run_instr(0, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("beq_not_taken", imem_addr, 32'h0000_0104);

        run_instr(3, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("stall_addr", imem_addr, 32'h0000_0108);

        run_instr(0, 32'h1000_8000, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("beq_back_wrap", imem_addr, 32'hFFFE_010C);
        run_instr(0, 32'h0FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("jal_top", imem_addr, 32'hFFFF_FFFC);
        run_instr(1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("pc_wrap", imem_addr, 32'h0000_0000);

        run_instr(0, 32'h0FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        run_instr(0, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("region_cross", imem_addr, 32'h1000_0000);
        run_instr(0, 32'h0C00_0040, 1'bx, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        chk("jal_region", imem_addr, 32'h1000_0100);

        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        #1;
        chk("abort_fetch_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("abort_fetch_instr", instr, 32'd0);
        chk("abort_fetch_retired", retired, 32'd0);
        rst = 1'b0;
        imem_ready = 1'b0;
        m_pc  = RPC;
        m_ret = '0;
        m_mis = 1'b0;
        #1;
        chk("refetch_addr", imem_addr, RPC);

        run_instr(2, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        run_instr(1, 32'h2008_0005, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("post_abort_addr", imem_addr, RPC);

`ifdef FETCH_JR_EN
        run_instr(0, 32'h0000_0008, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2002, 1'b0);
        chk("jr_addr", imem_addr, 32'h0000_2000);
        chk("jr_misalign", 32'(misalign), 32'd1);
        run_instr(0, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("jr_misalign_clear", 32'(misalign), 32'd0);
`endif

        for (int n = 0; n < 300; n++) begin
            word = {ops[$urandom_range(7)], 26'($urandom)};
`ifdef FETCH_JR_EN
            jrv = ($urandom_range(7) == 0);
`else
            jrv = 1'b0;
`endif
            run_instr(int'($urandom_range(3)), word, 1'($urandom),
                      ($urandom_range(3) == 0), 1'($urandom), jrv, $urandom, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
